// File: rtl/icache_pkg.sv
// Shared types and address-split helpers for the set-associative instruction cache.
// No logic; widths derive from the cache geometry parameters.
package icache_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FILL   = 2'd1,
      COMMIT = 2'd2
   } state_t;

   function automatic int off_w(input int line_words);
      return $clog2(line_words);
   endfunction

   function automatic int idx_w(input int sets);
      return $clog2(sets);
   endfunction

   // Tag keeps every byte-address bit above index, offset and the byte lane.
   function automatic int tag_w(input int addr_w, input int sets, input int line_words);
      return addr_w - $clog2(sets) - $clog2(line_words) - 2;
   endfunction

endpackage

// File: rtl/icache_sa_param_if.sv
// Fetch-side and refill-side signals of the instruction cache.
// The cache is the slave; fetch stage plus memory together form the master.
interface icache_sa_param_if #(
   parameter int ADDR_W = 32
);
   logic [ADDR_W-1:0] pc_addr;
   logic              pc_valid;
   logic              inv;
   logic [31:0]       instr;
   logic              hit;
   logic              stall;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_rdata;
   logic              mem_rvalid;

   modport master (
      output pc_addr, pc_valid, inv, mem_rdata, mem_rvalid,
      input  instr, hit, stall, mem_req, mem_addr
   );

   modport slave (
      input  pc_addr, pc_valid, inv, mem_rdata, mem_rvalid,
      output instr, hit, stall, mem_req, mem_addr
   );
endinterface

// File: rtl/icache_way.sv
// One cache way: data, tag and valid arrays with combinational read and tag compare.
// Read is zero-latency; writes land on the clock edge; no backpressure.
module icache_way #(
   parameter int SETS       = 16,
   parameter int LINE_WORDS = 4,
   parameter int IDX_W      = 4,
   parameter int OFF_W      = 2,
   parameter int TAG_W      = 26
) (
   input  logic             clk,
   input  logic             RESET,
   input  logic [IDX_W-1:0] rd_idx,
   input  logic [OFF_W-1:0] rd_off,
   input  logic [TAG_W-1:0] rd_tag,
   output logic             match,
   output logic             set_valid,
   output logic [31:0]      rd_data,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [OFF_W-1:0] wr_off,
   input  logic [31:0]      wr_data,
   input  logic             commit,
   input  logic [TAG_W-1:0] wr_tag,
   input  logic             inv_all
);
   logic [31:0]      data_mem [SETS*LINE_WORDS];
   logic [TAG_W-1:0] tag_mem  [SETS];
   logic [SETS-1:0]  valid_q;

   // Only valid bits are reset; invalidate beats a same-edge commit.
   always_ff @(posedge clk) begin
      if (RESET || inv_all) begin
         valid_q <= '0;
      end else if (commit) begin
         valid_q[wr_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         data_mem[{wr_idx, wr_off}] <= wr_data;
      end
      if (commit) begin
         tag_mem[wr_idx] <= wr_tag;
      end
   end

   assign set_valid = valid_q[rd_idx];
   assign match     = set_valid && (tag_mem[rd_idx] == rd_tag);
   assign rd_data   = data_mem[{rd_idx, rd_off}];
endmodule

// File: rtl/icache_sa_param.sv
// Set-associative instruction cache: same-cycle hit, miss refills a line by word reads.
// Miss latency LINE_WORDS handshakes + 2 cycles; stall freezes fetch; one mem request outstanding.
module icache_sa_param
   import icache_pkg::*;
#(
   parameter int WAYS       = 2,
   parameter int SETS       = 16,
   parameter int LINE_WORDS = 4,
   parameter int ADDR_W     = 32
) (
   input logic              clk,
   input logic              RESET,
   icache_sa_param_if.slave bus
);
   localparam int OFF_W = off_w(LINE_WORDS);
   localparam int IDX_W = idx_w(SETS);
   localparam int TAG_W = tag_w(ADDR_W, SETS, LINE_WORDS);
   localparam int PTR_W = (WAYS > 1) ? $clog2(WAYS) : 1;

   logic [OFF_W-1:0]  pc_off;
   logic [IDX_W-1:0]  pc_idx;
   logic [TAG_W-1:0]  pc_tag;
   logic              unused_pc_lsb;

   logic [WAYS-1:0]   way_match;
   logic [WAYS-1:0]   way_vld;
   logic [31:0]       way_data [WAYS];
   logic [31:0]       hit_data;
   logic              hit;

   state_t            state;
   logic [OFF_W-1:0]  cnt;
   logic [IDX_W-1:0]  f_idx;
   logic [TAG_W-1:0]  f_tag;
   logic [PTR_W-1:0]  victim_q;
   logic [PTR_W-1:0]  victim;
   logic [PTR_W-1:0]  ptr_sel;
   logic              mem_req_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic              fill_wr;
   logic              commit_wr;

   assign pc_off        = bus.pc_addr[OFF_W+1:2];
   assign pc_idx        = bus.pc_addr[OFF_W+2 +: IDX_W];
   assign pc_tag        = bus.pc_addr[ADDR_W-1 -: TAG_W];
   assign unused_pc_lsb = ^bus.pc_addr[1:0];

   // An abort on the same edge suppresses both the data write and the commit.
   assign fill_wr   = (state == FILL) && bus.mem_rvalid && !bus.inv;
   assign commit_wr = (state == COMMIT) && !bus.inv;

   for (genvar g = 0; g < WAYS; g++) begin : g_way
      icache_way #(
         .SETS       (SETS),
         .LINE_WORDS (LINE_WORDS),
         .IDX_W      (IDX_W),
         .OFF_W      (OFF_W),
         .TAG_W      (TAG_W)
      ) u_way (
         .clk       (clk),
         .RESET     (RESET),
         .rd_idx    (pc_idx),
         .rd_off    (pc_off),
         .rd_tag    (pc_tag),
         .match     (way_match[g]),
         .set_valid (way_vld[g]),
         .rd_data   (way_data[g]),
         .wr_en     (fill_wr && (victim_q == PTR_W'(g))),
         .wr_idx    (f_idx),
         .wr_off    (cnt),
         .wr_data   (bus.mem_rdata),
         .commit    (commit_wr && (victim_q == PTR_W'(g))),
         .wr_tag    (f_tag),
         .inv_all   (bus.inv)
      );
   end

   if (WAYS > 1) begin : g_rr
      logic [PTR_W-1:0] rr_ptr [SETS];

      always_ff @(posedge clk) begin
         if (RESET) begin
            for (int s = 0; s < SETS; s++) begin
               rr_ptr[s] <= '0;
            end
         end else if (commit_wr) begin
            rr_ptr[f_idx] <= rr_ptr[f_idx] + 1'b1;
         end
      end

      assign ptr_sel = rr_ptr[pc_idx];
   end else begin : g_no_rr
      assign ptr_sel = '0;
   end

   // Descending scans so the lowest matching / lowest invalid way wins.
   always_comb begin
      hit_data = way_data[0];
      victim   = ptr_sel;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (way_match[w]) begin
            hit_data = way_data[w];
         end
         if (!way_vld[w]) begin
            victim = PTR_W'(w);
         end
      end
   end

   assign hit       = bus.pc_valid && (state == IDLE) && (|way_match);
   assign bus.hit   = hit;
   assign bus.instr = hit_data;
   assign bus.stall = (bus.pc_valid && !hit) || (state != IDLE);

   assign bus.mem_req  = mem_req_q;
   assign bus.mem_addr = mem_addr_q;

   always_ff @(posedge clk) begin
      if (RESET) begin
         state      <= IDLE;
         cnt        <= '0;
         f_idx      <= '0;
         f_tag      <= '0;
         victim_q   <= '0;
         mem_req_q  <= 1'b0;
         mem_addr_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.pc_valid && !hit) begin
                  f_idx      <= pc_idx;
                  f_tag      <= pc_tag;
                  victim_q   <= victim;
                  cnt        <= '0;
                  mem_req_q  <= 1'b1;
                  mem_addr_q <= {pc_tag, pc_idx, {(OFF_W + 2){1'b0}}};
                  state      <= FILL;
               end
            end
            FILL: begin
               if (bus.inv) begin
                  mem_req_q <= 1'b0;
                  state     <= IDLE;
               end else if (bus.mem_rvalid) begin
                  cnt <= cnt + 1'b1;
                  if (cnt == OFF_W'(LINE_WORDS - 1)) begin
                     mem_req_q <= 1'b0;
                     state     <= COMMIT;
                  end else begin
                     mem_addr_q <= mem_addr_q + ADDR_W'(4);
                  end
               end
            end
            COMMIT: begin
               state <= IDLE;
            end
            default: begin
               mem_req_q <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_icache_sa_param.sv
// Bench for icache_sa_param: directed scenarios on a 2-way cache, then random fetch
// streams on 1-, 2- and 4-way caches against a line-level reference model.
module tb_icache_sa_param;
   localparam int SETS = 16;
   localparam int LW   = 4;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [31:0] pc;
   logic        pv;
   logic        inv_p;
   int          sel = 1;
   logic [31:0] rdata;
   logic        rv;

   logic [31:0] o_instr, o_addr;
   logic        o_hit, o_stall, o_req;

   int          checks = 0;
   int          errors = 0;
   int          dmin = 1;
   int          dmax = 1;
   bit          busy = 1'b0;
   logic [31:0] req_log [$];

   int          mways;
   bit          mvalid [SETS][4];
   int          mline  [SETS][4];
   int          mptr   [SETS];

   icache_sa_param_if #(.ADDR_W(32)) bus_w1 ();
   icache_sa_param_if #(.ADDR_W(32)) bus_w2 ();
   icache_sa_param_if #(.ADDR_W(32)) bus_w4 ();

   icache_sa_param #(.WAYS(1), .SETS(SETS), .LINE_WORDS(LW), .ADDR_W(32))
      u_w1 (.clk(clk), .RESET(rst), .bus(bus_w1));
   icache_sa_param #(.WAYS(2), .SETS(SETS), .LINE_WORDS(LW), .ADDR_W(32))
      u_w2 (.clk(clk), .RESET(rst), .bus(bus_w2));
   icache_sa_param #(.WAYS(4), .SETS(SETS), .LINE_WORDS(LW), .ADDR_W(32))
      u_w4 (.clk(clk), .RESET(rst), .bus(bus_w4));

   // Only the selected cache sees fetches and refill data; the others sit idle.
   assign bus_w1.pc_addr    = pc;
   assign bus_w1.pc_valid   = pv && (sel == 0);
   assign bus_w1.inv        = inv_p && (sel == 0);
   assign bus_w1.mem_rdata  = rdata;
   assign bus_w1.mem_rvalid = rv && (sel == 0);
   assign bus_w2.pc_addr    = pc;
   assign bus_w2.pc_valid   = pv && (sel == 1);
   assign bus_w2.inv        = inv_p && (sel == 1);
   assign bus_w2.mem_rdata  = rdata;
   assign bus_w2.mem_rvalid = rv && (sel == 1);
   assign bus_w4.pc_addr    = pc;
   assign bus_w4.pc_valid   = pv && (sel == 2);
   assign bus_w4.inv        = inv_p && (sel == 2);
   assign bus_w4.mem_rdata  = rdata;
   assign bus_w4.mem_rvalid = rv && (sel == 2);

   always_comb begin
      o_instr = bus_w4.instr;
      o_hit   = bus_w4.hit;
      o_stall = bus_w4.stall;
      o_req   = bus_w4.mem_req;
      o_addr  = bus_w4.mem_addr;
      if (sel == 0) begin
         o_instr = bus_w1.instr;
         o_hit   = bus_w1.hit;
         o_stall = bus_w1.stall;
         o_req   = bus_w1.mem_req;
         o_addr  = bus_w1.mem_addr;
      end else if (sel == 1) begin
         o_instr = bus_w2.instr;
         o_hit   = bus_w2.hit;
         o_stall = bus_w2.stall;
         o_req   = bus_w2.mem_req;
         o_addr  = bus_w2.mem_addr;
      end
   end

   function automatic logic [31:0] memw(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   // Main memory: answers each request after dmin..dmax idle cycles with a one-cycle rvalid.
   initial begin
      logic [31:0] ra;
      int          rd;
      rv    = 1'b0;
      rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         rv   = 1'b0;
         busy = 1'b0;
         if (o_req === 1'b1) begin
            ra = o_addr;
            req_log.push_back(ra);
            busy = 1'b1;
            rd = $urandom_range(dmax, dmin);
            repeat (rd) begin
               @(posedge clk);
               #1;
            end
            rdata = memw(ra);
            rv    = 1'b1;
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not complete (errors so far %0d)", errors);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference model: each way holds a line number (byte address / 16).
   function automatic bit model_lookup(input logic [31:0] a);
      int line = int'(a >> 4);
      int set  = line % SETS;
      for (int w = 0; w < mways; w++) begin
         if (mvalid[set][w] && mline[set][w] == line) return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic model_fill(input logic [31:0] a);
      int line = int'(a >> 4);
      int set  = line % SETS;
      int vic  = -1;
      for (int w = 0; w < mways; w++) begin
         if (vic < 0 && !mvalid[set][w]) vic = w;
      end
      if (vic < 0) vic = mptr[set] % mways;
      mline[set][vic]  = line;
      mvalid[set][vic] = 1'b1;
      mptr[set]++;
   endtask

   task automatic model_inv();
      for (int s = 0; s < SETS; s++)
         for (int w = 0; w < 4; w++) mvalid[s][w] = 1'b0;
   endtask

   task automatic model_reset();
      model_inv();
      for (int s = 0; s < SETS; s++) mptr[s] = 0;
   endtask

   // Presents one fetch and holds it until the hit; lat < 0 skips the latency check.
   task automatic fetch(input logic [31:0] a, input int lat);
      bit exp_hit;
      int n;
      @(negedge clk);
      pc = a;
      pv = 1'b1;
      #1;
      exp_hit = model_lookup(a);
      check("hit_first_cycle", o_hit, exp_hit);
      if (exp_hit) begin
         check("instr_on_hit", o_instr, memw(a));
         check("stall_on_hit", o_stall, 1'b0);
         check("mem_req_on_hit", o_req, 1'b0);
      end else begin
         n = 0;
         while (o_hit !== 1'b1 && n < 200) begin
            check("stall_during_miss", o_stall, 1'b1);
            @(negedge clk);
            #1;
            n++;
         end
         check("refill_completes", o_hit, 1'b1);
         if (lat >= 0) check("miss_latency", n, lat);
         check("instr_after_refill", o_instr, memw(a));
         model_fill(a);
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("memory_idle", busy, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      pv    = 1'b0;
      inv_p = 1'b0;
      rst   = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check("reset_hit", o_hit, 1'b0);
      check("reset_stall", o_stall, 1'b0);
      check("reset_mem_req", o_req, 1'b0);
      check("reset_mem_addr", o_addr, 32'h0);
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      int base;
      int n;
      logic [31:0] a;
      rst   = 1'b1;
      pv    = 1'b0;
      inv_p = 1'b0;
      pc    = '0;
      mways = 2;
      sel   = 1;

      // Cold miss with a one-cycle memory: 4 x (1+1) handshake cycles + 2.
      do_reset();
      req_log.delete();
      fetch(32'h100, LW * 2 + 2);
      check("t1_req_count", req_log.size(), 4);
      for (int i = 0; i < req_log.size() && i < 4; i++)
         check("t1_req_addr", req_log[i], 32'h100 + 32'(4 * i));

      // Spatial hits in the freshly filled line.
      fetch(32'h104, -1);
      fetch(32'h108, -1);
      fetch(32'h10C, -1);

      // Three lines in set 0 of a 2-way cache: the third evicts the first.
      dmin = 0;
      dmax = 0;
      do_reset();
      fetch(32'h000, LW + 2);
      fetch(32'h100, LW + 2);
      fetch(32'h200, LW + 2);
      check("t3_0x100_resident", model_lookup(32'h100), 1'b1);
      fetch(32'h100, -1);
      fetch(32'h000, LW + 2);

      // Invalidate then refetch; then invalidate in the middle of a refill.
      @(negedge clk);
      pv    = 1'b0;
      inv_p = 1'b1;
      @(negedge clk);
      inv_p = 1'b0;
      model_inv();
      fetch(32'h100, LW + 2);
      dmin = 2;
      dmax = 2;
      base = req_log.size();
      @(negedge clk);
      pc = 32'h300;
      pv = 1'b1;
      n  = 0;
      while (req_log.size() < base + 2 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("t4_second_word_requested", req_log.size() - base, 2);
      inv_p = 1'b1;
      pv    = 1'b0;
      @(negedge clk);
      inv_p = 1'b0;
      #1;
      check("t4_abort_mem_req", o_req, 1'b0);
      check("t4_abort_stall", o_stall, 1'b0);
      model_inv();
      wait_idle();
      repeat (3) @(negedge clk);
      #1;
      check("t4_late_rvalid_mem_req", o_req, 1'b0);
      check("t4_late_rvalid_stall", o_stall, 1'b0);
      fetch(32'h300, LW * 3 + 2);

      // Reset while the third word is outstanding.
      base = req_log.size();
      @(negedge clk);
      pc = 32'h400;
      pv = 1'b1;
      n  = 0;
      while (req_log.size() < base + 3 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("t5_third_word_requested", req_log.size() - base, 3);
      rst = 1'b1;
      pv  = 1'b0;
      @(negedge clk);
      #1;
      check("t5_reset_mem_req", o_req, 1'b0);
      check("t5_reset_stall", o_stall, 1'b0);
      rst = 1'b0;
      model_reset();
      wait_idle();
      repeat (3) @(negedge clk);
      #1;
      check("t5_late_rvalid_mem_req", o_req, 1'b0);
      fetch(32'h400, LW * 3 + 2);

      // Random fetch streams with random memory delay, one run per associativity.
      for (int s = 0; s < 3; s++) begin
         @(negedge clk);
         pv = 1'b0;
         wait_idle();
         sel   = s;
         mways = (s == 0) ? 1 : (s == 1) ? 2 : 4;
         dmin  = 0;
         dmax  = 5;
         do_reset();
         for (int k = 0; k < 150; k++) begin
            if ($urandom_range(0, 19) == 0) begin
               @(negedge clk);
               pv    = 1'b0;
               inv_p = 1'b1;
               @(negedge clk);
               inv_p = 1'b0;
               model_inv();
            end
            a = 32'($urandom_range(0, 47) * 16 + $urandom_range(0, 3) * 4);
            fetch(a, -1);
         end
      end

      @(negedge clk);
      pv = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
